// File: rtl/btn_pulse_gen_if.sv
// Button conditioner bus: raw pad inputs in, debounced level and
// press/release pulses out. The design side uses the slave modport,
// the pad/consumer side uses master.
interface btn_pulse_gen_if #(
    parameter int NUM_BTN = 4
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [NUM_BTN-1:0] btn_release;
    logic               any_press;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  any_press
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output any_press
    );
endinterface

// File: rtl/btn_pulse_gen.sv
// Multi-channel push-button conditioner: per channel a 2-flop synchronizer,
// a restart-on-agreement debouncer and a HELD/REPEAT FSM producing
// registered one-cycle press and release pulses.
// Optional macro BTN_PULSE_GEN_AUTO_REPEAT_EN: a held key emits repeat press
// pulses after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles. Without
// it a debounced press yields exactly one press pulse and no repeat counter.
module btn_pulse_gen #(
    parameter int NUM_BTN         = 4,
    parameter int BTN_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W = $clog2(
        (((DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY) > REPEAT_PERIOD
            ? ((DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY)
            : REPEAT_PERIOD) + 1)
) (
    input logic            clk,
    input logic            rst,
    btn_pulse_gen_if.slave bus
);

    // Pad value of a released key; also the synchronizer reset value.
    localparam logic RELEASED = (BTN_ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_PULSE_GEN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } state_t;

    logic [NUM_BTN-1:0] level_v;
    logic [NUM_BTN-1:0] press_v;
    logic [NUM_BTN-1:0] release_v;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic             sync1;
        logic             sync2;
        logic             pressed;
        logic             level_q;
        logic [CNT_W-1:0] dcnt;
        logic             rise;
        logic             fall;
        state_t           state_q;
        state_t           state_d;
        logic             press_q;
        logic             press_d;
        logic             release_q;
        logic             release_d;
`ifdef BTN_PULSE_GEN_AUTO_REPEAT_EN
        logic [CNT_W-1:0] rcnt_q;
        logic [CNT_W-1:0] rcnt_d;
`endif

        // Two-flop synchronizer; reset parks both flops at the released value
        // so a key held through reset has to debounce again afterwards.
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1 <= RELEASED;
                sync2 <= RELEASED;
            end else begin
                sync1 <= bus.btn_raw[i];
                sync2 <= sync1;
            end
        end

        assign pressed = sync2 ^ RELEASED;

        // Level flips on the edge where a full disagreement run completes.
        always_comb begin
            rise = pressed && !level_q && (dcnt == DB_LAST);
            fall = !pressed && level_q && (dcnt == DB_LAST);
        end

        // Debouncer: any cycle of agreement restarts the disagreement count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                level_q <= 1'b0;
                dcnt    <= '0;
            end else if (pressed == level_q) begin
                dcnt <= '0;
            end else if (dcnt == DB_LAST) begin
                level_q <= pressed;
                dcnt    <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end

        // FSM next state and pulse decode; release wins over a same-cycle repeat.
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        always_comb begin
            state_d   = state_q;
            press_d   = 1'b0;
            release_d = 1'b0;
`ifdef BTN_PULSE_GEN_AUTO_REPEAT_EN
            rcnt_d    = rcnt_q;
`endif
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HELD;
                        press_d = 1'b1;
`ifdef BTN_PULSE_GEN_AUTO_REPEAT_EN
                        rcnt_d  = '0;
`endif
                    end
                end
                HELD: begin
                    if (fall) begin
                        state_d   = IDLE;
                        release_d = 1'b1;
`ifdef BTN_PULSE_GEN_AUTO_REPEAT_EN
                        rcnt_d    = '0;
                    end else if (rcnt_q == RD_LAST) begin
                        state_d = REPEAT;
                        press_d = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
`endif
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        state_d   = IDLE;
                        release_d = 1'b1;
`ifdef BTN_PULSE_GEN_AUTO_REPEAT_EN
                        rcnt_d    = '0;
                    end else if (rcnt_q == RP_LAST) begin
                        press_d = 1'b1;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // FSM state and registered pulse outputs.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q   <= IDLE;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef BTN_PULSE_GEN_AUTO_REPEAT_EN
                rcnt_q    <= '0;
`endif
            end else begin
                state_q   <= state_d;
                press_q   <= press_d;
                release_q <= release_d;
`ifdef BTN_PULSE_GEN_AUTO_REPEAT_EN
                rcnt_q    <= rcnt_d;
`endif
            end
        end

        assign level_v[i]   = level_q;
        assign press_v[i]   = press_q;
        assign release_v[i] = release_q;
    end

    assign bus.btn_level   = level_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = release_v;
    assign bus.any_press   = |press_v;

endmodule
